ram_group_uram_mb: RTL and testbench
====================================

Name: ram_group_uram_mb

Overview:
- Parametrised successor to the fixed 4-bank URAM group: NUM_BANKS independent true-dual-port URAM banks.
- Each bank sits behind a configurable input pipeline.
- Adds per-port read-valid tracking, same-address collision resolution with write forwarding, and a collision event counter.
- Sits between socket compute kernels and on-chip buffer storage.

Parameters:
- NUM_BANKS, 4, number of banks (1..16).
- AWIDTH, 12, word address width per bank.
- DWIDTH, 64, data width per port.
- DEPTH, 4096, words per bank; must satisfy DEPTH <= 2**AWIDTH.
- IN_STAGES, 1, register stages on addr/d/ce/we before the RAM (1..4).
- CNT_WIDTH, 16, width of the collision counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- addr0  in  NUM_BANKS*AWIDTH  port-0 addresses; bank b in slice [b*AWIDTH +: AWIDTH], same slicing for all buses.
- d0  in  NUM_BANKS*DWIDTH  port-0 write data.
- ce0  in  NUM_BANKS  port-0 enables.
- we0  in  NUM_BANKS  port-0 write enables.
- q0  out  NUM_BANKS*DWIDTH  port-0 read data.
- q0_valid  out  NUM_BANKS  port-0 read data valid.
- addr1, d1, ce1, we1, q1, q1_valid: port-1 equivalents, same widths.
- coll_cnt  out  CNT_WIDTH  saturating count of collision events.
- coll_clr  in  1  synchronous clear of coll_cnt.

Behaviour:
- Input pipeline:
  - Each bank/port registers addr, d, ce, we through IN_STAGES stages.
  - ce/we stages reset asynchronously to 0; addr/d stages have no reset.
- RAM access:
  - Each bank is one SYNC_RAM_DP_URAM instance, read latency 1.
  - Access occurs when the last-stage ce=1.
  - Read = ce&~we; write = ce&we.
- Read latency, request to q/q_valid: IN_STAGES+1 cycles (2 at defaults).
- Read valid:
  - qX_valid[b] pulses high for exactly one cycle per read request, aligned with the data.
  - Writes never raise valid.
  - q holds its last value when valid is 0.
- Collision detection:
  - Evaluated per bank at the last pipeline stage.
  - A collision is both ports ce=1 with equal addresses and at least one write.
  - Both write: port-0 data is stored and port-1's write is suppressed.
  - One writes, other reads: the read port returns the write data (forwarded) in place of the RAM output, with valid asserted normally.
  - Both read: not a collision.
- coll_cnt:
  - Increments by the number of banks colliding in that cycle (0..NUM_BANKS).
  - Saturates at all-ones.
  - coll_clr has priority over increment in the same cycle; the result is 0.
  - Resets to 0.
- Reset values: q0, q1 = 0; q0_valid, q1_valid = 0; coll_cnt = 0.
- Reset mid-operation:
  - In-flight requests are discarded; valid stays 0 until new requests complete their full latency.
  - RAM contents are not cleared.
- Out-of-range address (addr >= DEPTH): reads return 0 with valid=1; writes are ignored; not counted as a collision.
- Banks are fully independent; there is no cross-bank interaction.

Optional Feature:
- Macro: RAM_GROUP_OUT_REG_EN.
- Defined:
  - An extra output register stage on q and q_valid (forwarded data included).
  - Read latency becomes IN_STAGES+2.
  - Output registers reset to 0.
- Undefined:
  - q comes straight from the RAM output or forward mux.
  - Latency is IN_STAGES+1.
- Collision counting timing is unchanged in both builds.

Test Plan:
- Bank 2, port 0: write addr 0x010 d=0xDEADBEEF_00000001, then port-1 read of 0x010 -> q1 slice 2 = 0xDEADBEEF_00000001 with q1_valid[2] high exactly 2 cycles after the read request, no other valid bits set.
- Bank 0: both ports write addr 0x020 (d0=0xA, d1=0xB) in the same cycle, then a read -> returns 0xA; coll_cnt=1.
- Bank 1: port 0 writes 0x030 d=0x55 while port 1 reads 0x030 in the same cycle -> q1 = 0x55 forwarded, valid at latency 2; coll_cnt increments by 1.
- Same-address write collisions on all 4 banks in one cycle -> coll_cnt +4.
- Saturation: preload coll_cnt to 0xFFFF via collisions, one more collision -> stays 0xFFFF.
- coll_clr asserted concurrently with a collision -> coll_cnt = 0.
- Issue reads to all banks, assert rst low for 1 cycle before data returns -> no valid pulses, q=0.
- After reset, re-read previously written data -> original values returned.
- With RAM_GROUP_OUT_REG_EN defined and IN_STAGES=2: read request -> valid at cycle +4.

Source files
------------

// File: rtl/ram_group_uram_mb.sv
// ram_group_uram_mb: NUM_BANKS dual-port URAM banks with input pipeline, collision forwarding and counter.
// Define RAM_GROUP_OUT_REG_EN to add an output register stage on q/q_valid.
module ram_group_uram_mb #(
   parameter int NUM_BANKS = 4,
   parameter int AWIDTH    = 12,
   parameter int DWIDTH    = 64,
   parameter int DEPTH     = 4096,
   parameter int IN_STAGES = 1,
   parameter int CNT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_BANKS*AWIDTH-1:0] addr0,
   input  logic [NUM_BANKS*DWIDTH-1:0] d0,
   input  logic [NUM_BANKS-1:0]        ce0,
   input  logic [NUM_BANKS-1:0]        we0,
   output logic [NUM_BANKS*DWIDTH-1:0] q0,
   output logic [NUM_BANKS-1:0]        q0_valid,
   input  logic [NUM_BANKS*AWIDTH-1:0] addr1,
   input  logic [NUM_BANKS*DWIDTH-1:0] d1,
   input  logic [NUM_BANKS-1:0]        ce1,
   input  logic [NUM_BANKS-1:0]        we1,
   output logic [NUM_BANKS*DWIDTH-1:0] q1,
   output logic [NUM_BANKS-1:0]        q1_valid,
   output logic [CNT_WIDTH-1:0]        coll_cnt,
   input  logic                        coll_clr
);
   localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
   logic [NUM_BANKS-1:0] coll;
   logic [4:0]           nsum;
   logic [CNT_WIDTH:0]   tot;
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [AWIDTH-1:0]    a0_p [IN_STAGES];
      logic [AWIDTH-1:0]    a1_p [IN_STAGES];
      logic [DWIDTH-1:0]    d0_p [IN_STAGES];
      logic [DWIDTH-1:0]    d1_p [IN_STAGES];
      logic [IN_STAGES-1:0] c0_p, w0_p, c1_p, w1_p;
      logic [AWIDTH-1:0]    a0, a1;
      logic [DWIDTH-1:0]    wd0, wd1, rq0, rq1, fd0, fd1, m0, m1, qh0, qh1;
      logic                 c0, w0, c1, w1, in0, in1, rd0, rd1;
      logic                 rv0, rv1, oor0, oor1, fw0, fw1;
      always_ff @(posedge clk) begin
         a0_p[0] <= addr0[b*AWIDTH +: AWIDTH];
         a1_p[0] <= addr1[b*AWIDTH +: AWIDTH];
         d0_p[0] <= d0[b*DWIDTH +: DWIDTH];
         d1_p[0] <= d1[b*DWIDTH +: DWIDTH];
         for (int s = 1; s < IN_STAGES; s++) begin
            a0_p[s] <= a0_p[s-1];
            a1_p[s] <= a1_p[s-1];
            d0_p[s] <= d0_p[s-1];
            d1_p[s] <= d1_p[s-1];
         end
      end
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            c0_p <= '0;
            w0_p <= '0;
            c1_p <= '0;
            w1_p <= '0;
         end else begin
            c0_p[0] <= ce0[b];
            w0_p[0] <= we0[b];
            c1_p[0] <= ce1[b];
            w1_p[0] <= we1[b];
            for (int s = 1; s < IN_STAGES; s++) begin
               c0_p[s] <= c0_p[s-1];
               w0_p[s] <= w0_p[s-1];
               c1_p[s] <= c1_p[s-1];
               w1_p[s] <= w1_p[s-1];
            end
         end
      end
      assign a0  = a0_p[IN_STAGES-1];
      assign a1  = a1_p[IN_STAGES-1];
      assign wd0 = d0_p[IN_STAGES-1];
      assign wd1 = d1_p[IN_STAGES-1];
      assign c0  = c0_p[IN_STAGES-1];
      assign w0  = w0_p[IN_STAGES-1];
      assign c1  = c1_p[IN_STAGES-1];
      assign w1  = w1_p[IN_STAGES-1];
      assign in0 = {1'b0, a0} < DEPTH_W;
      assign in1 = {1'b0, a1} < DEPTH_W;
      assign rd0 = c0 & ~w0;
      assign rd1 = c1 & ~w1;
      assign coll[b] = c0 & c1 & in0 & in1 & (a0 == a1) & (w0 | w1);
      // on a double write only port 0 reaches the array
      SYNC_RAM_DP_URAM #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_ram (
         .clk  (clk),
         .addr0(a0),
         .d0   (wd0),
         .ce0  (c0 & in0),
         .we0  (w0),
         .q0   (rq0),
         .addr1(a1),
         .d1   (wd1),
         .ce1  (c1 & in1 & ~(coll[b] & w0)),
         .we1  (w1),
         .q1   (rq1)
      );
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            rv0  <= 1'b0;
            rv1  <= 1'b0;
            oor0 <= 1'b0;
            oor1 <= 1'b0;
            fw0  <= 1'b0;
            fw1  <= 1'b0;
         end else begin
            rv0 <= rd0;
            rv1 <= rd1;
            if (rd0) begin
               oor0 <= ~in0;
               fw0  <= coll[b];
            end
            if (rd1) begin
               oor1 <= ~in1;
               fw1  <= coll[b];
            end
         end
      end
      always_ff @(posedge clk) begin
         if (rd0) fd0 <= wd1;
         if (rd1) fd1 <= wd0;
      end
      assign m0 = fw0 ? fd0 : oor0 ? '0 : rq0;
      assign m1 = fw1 ? fd1 : oor1 ? '0 : rq1;
`ifdef RAM_GROUP_OUT_REG_EN
      logic vh0, vh1;
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            vh0 <= 1'b0;
            vh1 <= 1'b0;
            qh0 <= '0;
            qh1 <= '0;
         end else begin
            vh0 <= rv0;
            vh1 <= rv1;
            if (rv0) qh0 <= m0;
            if (rv1) qh1 <= m1;
         end
      end
      assign q0[b*DWIDTH +: DWIDTH] = qh0;
      assign q1[b*DWIDTH +: DWIDTH] = qh1;
      assign q0_valid[b] = vh0;
      assign q1_valid[b] = vh1;
`else
      // hold register keeps q stable (and 0 after reset) between read results
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            qh0 <= '0;
            qh1 <= '0;
         end else begin
            if (rv0) qh0 <= m0;
            if (rv1) qh1 <= m1;
         end
      end
      assign q0[b*DWIDTH +: DWIDTH] = rv0 ? m0 : qh0;
      assign q1[b*DWIDTH +: DWIDTH] = rv1 ? m1 : qh1;
      assign q0_valid[b] = rv0;
      assign q1_valid[b] = rv1;
`endif
   end
   always_comb begin
      nsum = '0;
      for (int i = 0; i < NUM_BANKS; i++) nsum = nsum + 5'(coll[i]);
      tot = {1'b0, coll_cnt} + (CNT_WIDTH+1)'(nsum);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) coll_cnt <= '0;
      else coll_cnt <= coll_clr ? '0 : tot[CNT_WIDTH] ? '1 : tot[CNT_WIDTH-1:0];
   end
endmodule

module SYNC_RAM_DP_URAM #(
   parameter int AWIDTH = 12,
   parameter int DWIDTH = 64,
   parameter int DEPTH  = 4096
) (
   input  logic              clk,
   input  logic [AWIDTH-1:0] addr0,
   input  logic [DWIDTH-1:0] d0,
   input  logic              ce0,
   input  logic              we0,
   output logic [DWIDTH-1:0] q0,
   input  logic [AWIDTH-1:0] addr1,
   input  logic [DWIDTH-1:0] d1,
   input  logic              ce1,
   input  logic              we1,
   output logic [DWIDTH-1:0] q1
);
   logic [DWIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (ce1 && we1) mem[addr1] <= d1;
      if (ce0 && we0) mem[addr0] <= d0;
      if (ce0 && !we0) q0 <= mem[addr0];
      if (ce1 && !we1) q1 <= mem[addr1];
   end
endmodule

// File: tb/tb_ram_group_uram_mb.sv
// tb_ram_group_uram_mb: directed checks of ram_group_uram_mb (DEPTH=3072 to expose out-of-range addresses).
module tb_ram_group_uram_mb;
`ifdef RAM_GROUP_OUT_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [47:0]  addr0, addr1;
   logic [255:0] d0, d1, q0, q1;
   logic [3:0]   ce0, we0, ce1, we1, q0_valid, q1_valid;
   logic [15:0]  coll_cnt;
   logic         coll_clr;
   int           total = 0;
   int           bad = 0;

   ram_group_uram_mb #(.DEPTH(3072)) dut (
      .clk(clk), .rst(rst),
      .addr0(addr0), .d0(d0), .ce0(ce0), .we0(we0), .q0(q0), .q0_valid(q0_valid),
      .addr1(addr1), .d1(d1), .ce1(ce1), .we1(we1), .q1(q1), .q1_valid(q1_valid),
      .coll_cnt(coll_cnt), .coll_clr(coll_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ce0 = '0; we0 = '0; ce1 = '0; we1 = '0;
   endtask

   task automatic op(input int p, input int b, input logic w, input logic [11:0] a, input logic [63:0] d);
      if (p == 0) begin
         ce0[b] = 1'b1; we0[b] = w; addr0[b*12 +: 12] = a; d0[b*64 +: 64] = d;
      end else begin
         ce1[b] = 1'b1; we1[b] = w; addr1[b*12 +: 12] = a; d1[b*64 +: 64] = d;
      end
   endtask

   task automatic all_coll(input logic [11:0] a);
      for (int b = 0; b < 4; b++) begin
         op(0, b, 1'b1, a, 64'h100 + 64'(b));
         op(1, b, 1'b1, a, 64'h200 + 64'(b));
      end
   endtask

   initial begin
      addr0 = '0; addr1 = '0; d0 = '0; d1 = '0; coll_clr = 1'b0;
      idle();
      repeat (2) tick();
      chk("rst_q0", q0[63:0] | q0[255:192], 64'h0);
      chk("rst_q1", q1[127:64] | q1[191:128], 64'h0);
      chk("rst_valid", {56'h0, q0_valid, q1_valid}, 64'h0);
      chk("rst_cnt", 64'(coll_cnt), 64'h0);
      rst = 1'b1;
      tick();
      // write then read back on the other port, bank 2
      op(0, 2, 1'b1, 12'h010, 64'hDEADBEEF_00000001);
      tick(); idle();
      op(1, 2, 1'b0, 12'h010, 64'h0);
      tick(); idle();
      repeat (LAT-2) tick();
      chk("rd_early", 64'(q1_valid), 64'h0);
      tick();
      chk("rd_valid", {56'h0, q0_valid, q1_valid}, 64'h04);
      chk("rd_data", q1[128 +: 64], 64'hDEADBEEF_00000001);
      tick();
      chk("rd_pulse", 64'(q1_valid), 64'h0);
      chk("rd_hold", q1[128 +: 64], 64'hDEADBEEF_00000001);
      // double write collision, bank 0
      op(0, 0, 1'b1, 12'h020, 64'hA);
      op(1, 0, 1'b1, 12'h020, 64'hB);
      tick(); idle(); tick();
      chk("ww_cnt", 64'(coll_cnt), 64'd1);
      op(0, 0, 1'b0, 12'h020, 64'h0);
      tick(); idle();
      repeat (LAT-1) tick();
      chk("ww_valid", 64'(q0_valid), 64'h1);
      chk("ww_data", q0[63:0], 64'hA);
      // write/read collision with forwarding, bank 1
      op(0, 1, 1'b1, 12'h030, 64'h55);
      op(1, 1, 1'b0, 12'h030, 64'h0);
      tick(); idle(); tick();
      chk("wr_cnt", 64'(coll_cnt), 64'd2);
      repeat (LAT-2) tick();
      chk("wr_valid", {56'h0, q0_valid, q1_valid}, 64'h02);
      chk("wr_fwd", q1[64 +: 64], 64'h55);
      // all four banks collide at once
      all_coll(12'h040);
      tick(); idle(); tick();
      chk("all_cnt", 64'(coll_cnt), 64'd6);
      // both reads at the same address is not a collision
      op(0, 3, 1'b0, 12'h040, 64'h0);
      op(1, 3, 1'b0, 12'h040, 64'h0);
      tick(); idle(); tick();
      chk("rr_cnt", 64'(coll_cnt), 64'd6);
      repeat (LAT-2) tick();
      chk("rr_valid", {56'h0, q0_valid, q1_valid}, 64'h88);
      chk("rr_data", q0[192 +: 64] ^ q1[192 +: 64], 64'h0);
      chk("rr_val", q0[192 +: 64], 64'h103);
      // out-of-range address: writes ignored, reads give 0, no collision
      op(0, 3, 1'b1, 12'hC10, 64'h77);
      op(1, 3, 1'b1, 12'hC10, 64'h88);
      tick(); idle(); tick();
      chk("oor_cnt", 64'(coll_cnt), 64'd6);
      op(0, 3, 1'b0, 12'hC10, 64'h0);
      tick(); idle();
      repeat (LAT-1) tick();
      chk("oor_valid", 64'(q0_valid), 64'h8);
      chk("oor_data", q0[192 +: 64], 64'h0);
      // clear alone, then saturate
      coll_clr = 1'b1;
      tick();
      coll_clr = 1'b0;
      chk("clr_cnt", 64'(coll_cnt), 64'd0);
      all_coll(12'h050);
      repeat (16383) tick();
      idle(); tick();
      chk("sat_fffc", 64'(coll_cnt), 64'hFFFC);
      op(0, 0, 1'b1, 12'h050, 64'h1);
      op(1, 0, 1'b1, 12'h050, 64'h2);
      repeat (2) tick();
      idle(); tick();
      chk("sat_fffe", 64'(coll_cnt), 64'hFFFE);
      all_coll(12'h050);
      tick(); idle(); tick();
      chk("sat_over", 64'(coll_cnt), 64'hFFFF);
      op(0, 0, 1'b1, 12'h050, 64'h1);
      op(1, 0, 1'b1, 12'h050, 64'h2);
      tick(); idle(); tick();
      chk("sat_hold", 64'(coll_cnt), 64'hFFFF);
      // clear wins over a concurrent collision
      op(0, 1, 1'b1, 12'h060, 64'h1);
      op(1, 1, 1'b1, 12'h060, 64'h2);
      tick(); idle();
      coll_clr = 1'b1;
      tick();
      coll_clr = 1'b0;
      chk("clr_coll", 64'(coll_cnt), 64'd0);
      // reset while reads are in flight
      for (int b = 0; b < 4; b++) begin
         op(0, b, 1'b0, 12'h020, 64'h0);
         op(1, b, 1'b0, 12'h030, 64'h0);
      end
      tick(); idle();
      rst = 1'b0;
      #1;
      chk("mid_valid0", {56'h0, q0_valid, q1_valid}, 64'h0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < LAT; i++) begin
         chk("mid_valid", {56'h0, q0_valid, q1_valid}, 64'h0);
         tick();
      end
      chk("mid_q0", q0[63:0] | q0[127:64] | q0[191:128] | q0[255:192], 64'h0);
      chk("mid_q1", q1[63:0] | q1[127:64] | q1[191:128] | q1[255:192], 64'h0);
      // contents survive reset
      op(0, 0, 1'b0, 12'h020, 64'h0);
      op(1, 1, 1'b0, 12'h030, 64'h0);
      op(0, 2, 1'b0, 12'h010, 64'h0);
      op(1, 3, 1'b0, 12'h040, 64'h0);
      tick(); idle();
      repeat (LAT-1) tick();
      chk("post_valid", {56'h0, q0_valid, q1_valid}, 64'h5A);
      chk("post_b0", q0[63:0], 64'hA);
      chk("post_b1", q1[64 +: 64], 64'h55);
      chk("post_b2", q0[128 +: 64], 64'hDEADBEEF_00000001);
      chk("post_b3", q1[192 +: 64], 64'h103);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
